// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generation and decryption (PRGA).
// Walks MSG_LEN bytes. For each byte it swaps S[i] and S[j] in s_memory,
// fetches the keystream byte S[S[i]+S[j]] and one ciphertext byte, and
// writes their XOR into the plaintext RAM. All memories are synchronous-read.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; i, j, k held at 0
// INC_I  | i <= i + 1
// RD_SI  | present address i to S
// WT_SI  | hold address i, capture si = S[i]
// CALC_J | j <= j + si
// RD_SJ  | present address j to S
// WT_SJ  | hold address j, capture sj = S[j]
// WR_SI  | S[i] <= sj
// WR_SJ  | S[j] <= si
// RD_F   | present S address si+sj and ciphertext address k
// WT_F   | hold addresses, capture f (keystream) and enc (ciphertext)
// WR_D   | plaintext[k] <= f ^ enc, k <= k + 1, last byte -> DONE
// DONE   | finish high until start drops
module rc4_prga_decrypt #(
  parameter int MSG_LEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       finish,
  output logic [7:0] s_addr,
  output logic [7:0] s_wr_data,
  output logic       s_wren,
  input  logic [7:0] s_q,
  output logic [7:0] emem_addr,
  input  logic [7:0] emem_q,
  output logic [7:0] dmem_addr,
  output logic [7:0] dmem_data,
  output logic       dmem_wren
);

  localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, INC_I, RD_SI, WT_SI, CALC_J, RD_SJ, WT_SJ,
    WR_SI, WR_SJ, RD_F, WT_F, WR_D, DONE
  } state_t;

  state_t state, state_nxt;

  logic [7:0] i, j, k, si, sj, f, enc;
  logic [7:0] f_addr;

  // keystream index wraps modulo 256 on purpose
  assign f_addr = si + sj;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // datapath registers, updated according to the current state
  always_ff @(posedge clk) begin
    if (reset) begin
      i   <= 8'd0;
      j   <= 8'd0;
      k   <= 8'd0;
      si  <= 8'd0;
      sj  <= 8'd0;
      f   <= 8'd0;
      enc <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          i <= 8'd0;
          j <= 8'd0;
          k <= 8'd0;
        end
        INC_I:  i  <= i + 8'd1;
        WT_SI:  si <= s_q;
        CALC_J: j  <= j + si;
        WT_SJ:  sj <= s_q;
        WT_F: begin
          f   <= s_q;
          enc <= emem_q;
        end
        WR_D:   k  <= k + 8'd1;
        default: ;
      endcase
    end
  end

  // next-state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    s_addr    = 8'd0;
    s_wr_data = 8'd0;
    s_wren    = 1'b0;
    emem_addr = 8'd0;
    dmem_addr = 8'd0;
    dmem_data = 8'd0;
    dmem_wren = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = INC_I;
      INC_I:  state_nxt = RD_SI;
      RD_SI: begin
        s_addr    = i;
        state_nxt = WT_SI;
      end
      WT_SI: begin
        s_addr    = i;
        state_nxt = CALC_J;
      end
      CALC_J: state_nxt = RD_SJ;
      RD_SJ: begin
        s_addr    = j;
        state_nxt = WT_SJ;
      end
      WT_SJ: begin
        s_addr    = j;
        state_nxt = WR_SI;
      end
      WR_SI: begin
        s_addr    = i;
        s_wr_data = sj;
        s_wren    = 1'b1;
        state_nxt = WR_SJ;
      end
      WR_SJ: begin
        s_addr    = j;
        s_wr_data = si;
        s_wren    = 1'b1;
        state_nxt = RD_F;
      end
      RD_F: begin
        s_addr    = f_addr;
        emem_addr = k;
        state_nxt = WT_F;
      end
      WT_F: begin
        s_addr    = f_addr;
        emem_addr = k;
        state_nxt = WR_D;
      end
      WR_D: begin
        dmem_addr = k;
        dmem_data = f ^ enc;
        dmem_wren = 1'b1;
        state_nxt = (k == LAST_K) ? DONE : INC_I;
      end
      DONE: begin
        finish = 1'b1;
        if (!start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: behavioural S/ciphertext/plaintext memories,
// software RC4 PRGA reference, randomized S permutations and ciphertext.
module tb_rc4_prga_decrypt;

  localparam int MSG_LEN = 32;
  localparam int TMAX    = 600;

  logic       clk = 1'b0;
  logic       reset, start, finish;
  logic [7:0] s_addr, s_wr_data, s_q, emem_addr, emem_q, dmem_addr, dmem_data;
  logic       s_wren, dmem_wren;

  rc4_prga_decrypt #(.MSG_LEN(MSG_LEN)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .s_addr(s_addr), .s_wr_data(s_wr_data), .s_wren(s_wren), .s_q(s_q),
    .emem_addr(emem_addr), .emem_q(emem_q),
    .dmem_addr(dmem_addr), .dmem_data(dmem_data), .dmem_wren(dmem_wren)
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem [256];
  logic [7:0] emem  [256];
  logic [7:0] dmem  [256];

  // synchronous-read memories, read before write
  always @(posedge clk) begin
    s_q    <= s_mem[s_addr];
    emem_q <= emem[emem_addr];
    if (s_wren)    s_mem[s_addr]   = s_wr_data;
    if (dmem_wren) dmem[dmem_addr] = dmem_data;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // per-cycle trace of a run; index n = state after edge n (edge 0 samples start)
  logic [7:0] t_saddr [TMAX];
  logic [7:0] t_swd   [TMAX];
  logic       t_swren [TMAX];
  logic [7:0] t_daddr [TMAX];
  logic       t_dwren [TMAX];

  // reference results
  logic [7:0] exp_d  [256];
  logic [7:0] exp_s  [256];
  logic [7:0] exp_sj [256];

  task automatic golden();
    logic [7:0] ms [256];
    logic [7:0] gi, gj, tmp;
    for (int x = 0; x < 256; x++) ms[x] = s_mem[x];
    gi = 0;
    gj = 0;
    for (int n = 0; n < MSG_LEN; n++) begin
      gi  = 8'(gi + 1);
      gj  = 8'(gj + ms[gi]);
      exp_sj[n] = ms[gj];
      tmp = ms[gi]; ms[gi] = ms[gj]; ms[gj] = tmp;
      exp_d[n] = ms[8'(ms[gi] + ms[gj])] ^ emem[n];
    end
    for (int x = 0; x < 256; x++) exp_s[x] = ms[x];
  endtask

  task automatic load_perm();
    logic [7:0] tmp;
    int r;
    for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
    for (int x = 255; x > 0; x--) begin
      r = $urandom_range(x, 0);
      tmp = s_mem[x]; s_mem[x] = s_mem[r]; s_mem[r] = tmp;
    end
  endtask

  task automatic load_cipher(input bit zero);
    for (int x = 0; x < 256; x++) begin
      emem[x] = zero ? 8'h00 : 8'($urandom);
      dmem[x] = 8'h5A;
    end
  endtask

  // call away from posedge with DUT in IDLE; returns at a negedge in DONE
  task automatic run_msg(output int fin_cycle);
    fin_cycle = -1;
    start = 1'b1;
    @(posedge clk);
    for (int n = 0; n < TMAX; n++) begin
      @(negedge clk);
      t_saddr[n] = s_addr;
      t_swd[n]   = s_wr_data;
      t_swren[n] = s_wren;
      t_daddr[n] = dmem_addr;
      t_dwren[n] = dmem_wren;
      if (finish) begin
        fin_cycle = n + 1;
        break;
      end
      @(posedge clk);
    end
    if (fin_cycle < 0) check("run_timeout", 0, 1);
  endtask

  task automatic compare_run(input string tag);
    int bad;
    for (int n = 0; n < MSG_LEN; n++)
      check($sformatf("%s dmem[%0d]", tag, n), dmem[n], exp_d[n]);
    bad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== exp_s[x]) bad++;
    check({tag, " s_final_bad"}, bad, 0);
  endtask

  task automatic drop_start();
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("finish_drop", finish, 0);
  endtask

  initial begin
    int fc, writes, lows;
    logic [7:0] s1;

    // reset with start held high, identity S, zero ciphertext
    for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
    load_cipher(1'b1);
    reset = 1'b1;
    start = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("reset_outs%0d", c),
            {finish, s_wren, dmem_wren, s_addr, s_wr_data, emem_addr, dmem_addr, dmem_data}, 0);
    end
    reset = 1'b0;
    golden();
    run_msg(fc);
    check("post_reset_rd_si_addr", t_saddr[1], 1);
    check("finish_cycle", fc, 11 * MSG_LEN + 1);
    check("dmem0", dmem[0], 8'h02);
    check("dmem1", dmem[1], 8'h05);
    check("same_addr_wr_si", {t_swren[6], t_saddr[6], t_swd[6]}, {1'b1, 8'd1, 8'd1});
    check("same_addr_wr_sj", {t_swren[7], t_saddr[7], t_swd[7]}, {1'b1, 8'd1, 8'd1});
    for (int n = 0; n < MSG_LEN; n += 7)
      check($sformatf("wr_d_timing%0d", n), {t_dwren[11*n+10], t_daddr[11*n+10]}, {1'b1, 8'(n)});
    compare_run("identity");

    // start held through DONE: no rerun, no writes
    writes = 0;
    lows = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (s_wren || dmem_wren) writes++;
      if (!finish) lows++;
    end
    check("done_hold_writes", writes, 0);
    check("done_hold_finish_low", lows, 0);
    drop_start();

    // rerun on the S left behind: i, j, k restart from 0
    load_cipher(1'b0);
    s1 = s_mem[1];
    golden();
    run_msg(fc);
    check("rerun_i", t_saddr[1], 1);
    check("rerun_j", t_saddr[4], s1);
    check("rerun_k", {t_dwren[10], t_daddr[10]}, {1'b1, 8'd0});
    compare_run("rerun");
    drop_start();

    // wrap of si+sj
    for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
    s_mem[1]    = 8'hF0;
    s_mem[8'hF0] = 8'h20;
    load_cipher(1'b0);
    golden();
    run_msg(fc);
    check("wrap_j", t_saddr[4], 8'hF0);
    check("wrap_rd_f", t_saddr[8], 8'h10);
    check("wrap_wr_si", {t_saddr[6], t_swd[6]}, {8'h01, 8'h20});
    check("wrap_wr_sj", {t_saddr[7], t_swd[7]}, {8'hF0, 8'hF0});
    compare_run("wrap");
    drop_start();

    // reset during WR_SI of byte 5 (state after edge 61)
    load_perm();
    load_cipher(1'b0);
    golden();
    start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 61; c++) @(posedge clk);
    @(negedge clk);
    check("mid_wr_si_seen", {s_wren, s_addr, s_wr_data}, {1'b1, 8'd6, exp_sj[5]});
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_reset_outs", {finish, s_wren, dmem_wren, s_addr}, 0);
    check("mid_reset_write_landed", s_mem[6], exp_sj[5]);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_reset_idle", {finish, s_wren, s_addr}, 0);
    load_perm();
    load_cipher(1'b0);
    golden();
    run_msg(fc);
    compare_run("after_reset");
    drop_start();

    // random runs
    for (int r = 0; r < 3; r++) begin
      load_perm();
      load_cipher(1'b0);
      golden();
      run_msg(fc);
      check($sformatf("rand%0d finish_cycle", r), fc, 11 * MSG_LEN + 1);
      compare_run($sformatf("rand%0d", r));
      drop_start();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
